// File: rtl/alu_pkg.sv
// Opcode encodings, controller state type and opcode legality helper shared by the ALU sharing block.
package alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t ADD = 4'd1;
  localparam opcode_t SUB = 4'd2;
  localparam opcode_t SLL = 4'd3;
  localparam opcode_t SRL = 4'd4;
  localparam opcode_t SRA = 4'd5;
  localparam opcode_t SLU = 4'd6;
  localparam opcode_t SLT = 4'd7;
  localparam opcode_t OR  = 4'd8;
  localparam opcode_t AND = 4'd9;
  localparam opcode_t XOR = 4'd10;
  localparam opcode_t SIU = 4'd11;
  localparam opcode_t AIU = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_legal_op(input opcode_t op);
    return (op >= ADD) && (op <= AIU);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; flags are {V,Z,N,C}. Shifts use the full B operand,
// SIU/AIU place B at bit WORDSIZE-IMMSIZE.
module alu
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int OPSIZE   = 4,
  parameter int IMMSIZE  = 20
) (
  input  logic [OPSIZE-1:0]   op,
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  output logic [WORDSIZE-1:0] r,
  output logic [3:0]          flags
);

  localparam int SH = WORDSIZE - IMMSIZE;

  logic signed [WORDSIZE-1:0] sa;
  logic signed [WORDSIZE-1:0] sb;
  logic [WORDSIZE:0]          sum;
  logic [WORDSIZE:0]          dif;
  logic                       c;
  logic                       v;

  assign sa  = a;
  assign sb  = b;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ADD: begin
        r = sum[WORDSIZE-1:0];
        c = sum[WORDSIZE];
        v = (a[WORDSIZE-1] == b[WORDSIZE-1]) && (r[WORDSIZE-1] != a[WORDSIZE-1]);
      end
      SUB: begin
        r = dif[WORDSIZE-1:0];
        c = dif[WORDSIZE];
      end
      SLL:     r = a << b;
      SRL:     r = a >> b;
      SRA:     r = sa >>> b;
      SLU:     r = {{(WORDSIZE-1){1'b0}}, a < b};
      SLT:     r = {{(WORDSIZE-1){1'b0}}, sa < sb};
      OR:      r = a | b;
      AND:     r = a & b;
      XOR:     r = a ^ b;
      SIU:     r = b << SH;
      AIU:     r = a + (b << SH);
      default: r = '0;
    endcase
  end

  assign flags = {v, (r == '0), r[WORDSIZE-1], c};

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr names the last granted requester (reset favours req0).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  assign grant = (valid == 2'b11) ? (ptr ? 2'b01 : 2'b10) : valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: IDLE grants, EXEC evaluates, RESP holds the result.
// Define ALU_FLAGS_EN to add the registered {V,Z,N,C} rsp_flags output.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int OPSIZE   = 4,
  parameter int IMMSIZE  = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [OPSIZE-1:0]   req0_op,
  input  logic [WORDSIZE-1:0] req0_a,
  input  logic [WORDSIZE-1:0] req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [OPSIZE-1:0]   req1_op,
  input  logic [WORDSIZE-1:0] req1_a,
  input  logic [WORDSIZE-1:0] req1_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [WORDSIZE-1:0] rsp_r,
  output logic                rsp_illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]          rsp_flags
`endif
);

  state_t              state;
  state_t              state_d;
  logic                idle;
  logic                accept;
  logic [1:0]          req_vld;
  logic [1:0]          grant;
  logic [OPSIZE-1:0]   op_p0;
  logic [WORDSIZE-1:0] a_p0;
  logic [WORDSIZE-1:0] b_p0;
  logic                id_p0;
  logic                legal_p0;
  logic [WORDSIZE-1:0] alu_r;
`ifdef ALU_FLAGS_EN
  logic [3:0]          alu_flags;
  logic                addsub_p0;
`else
  logic [3:0]          alu_flags_unused;
`endif

  assign idle    = (state == IDLE);
  assign req_vld = {req1_valid, req0_valid} & {2{idle & ~rst}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_vld),
    .advance (idle),
    .grant   (grant)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // p0: operands of the granted request
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p0 <= grant[1];
      op_p0 <= grant[1] ? req1_op : req0_op;
      a_p0  <= grant[1] ? req1_a  : req0_a;
      b_p0  <= grant[1] ? req1_b  : req0_b;
    end
  end

  assign legal_p0 = is_legal_op(op_p0);

  alu #(
    .WORDSIZE (WORDSIZE),
    .OPSIZE   (OPSIZE),
    .IMMSIZE  (IMMSIZE)
  ) u_alu (
    .op    (op_p0),
    .a     (a_p0),
    .b     (b_p0),
    .r     (alu_r),
`ifdef ALU_FLAGS_EN
    .flags (alu_flags)
`else
    .flags (alu_flags_unused)
`endif
  );

  // p1: response registers, held until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_r       <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_p0;
          rsp_r       <= legal_p0 ? alu_r : '0;
          rsp_illegal <= ~legal_p0;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  assign addsub_p0 = (op_p0 == ADD) || (op_p0 == SUB);

  // Carry is only defined for ADD/SUB; everything else reports C=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_flags <= 4'b0000;
    end else if (state == EXEC) begin
      rsp_flags <= {alu_flags[3:1], alu_flags[0] & addsub_p0};
    end
  end
`endif

endmodule
